// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional macro FETCH_PERF_EN adds saturating fetch/flush performance counters.
module fetch_stage #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] NOP_INSTR    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] JumpTarget,
  input  logic [15:0] BranchTarget,
  input  logic [15:0] ReturnAddr,
  input  logic        stall,
  input  logic        halt,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic [15:0] pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] flush_count
`endif
);

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]  state;
  logic [15:0] pc_plus1;
  logic        advance;
  logic        fetch_event;
  logic        flush_event;

  assign imem_addr = pc;
  assign pc_plus1  = pc + 16'd1;

  // halt outranks stall, which in turn outranks any redirect request
  assign advance     = (state == RUN) && !halt && !stall;
  assign fetch_event = advance && (PCSrc == 2'b00);
  assign flush_event = advance && (PCSrc != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= BOOT;
      pc            <= RESET_VECTOR;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus1 <= 16'h0000;
      ifid_valid    <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          ifid_instr    <= NOP_INSTR;
          ifid_pc_plus1 <= 16'h0000;
          ifid_valid    <= 1'b0;
          state         <= RUN;
        end
        RUN: begin
          if (halt) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus1 <= 16'h0000;
            ifid_valid    <= 1'b0;
            state         <= HALT;
          end else if (!stall) begin
            if (PCSrc == 2'b00) begin
              pc            <= pc_plus1;
              ifid_instr    <= imem_data;
              ifid_pc_plus1 <= pc_plus1;
              ifid_valid    <= 1'b1;
            end else begin
              case (PCSrc)
                2'b01:   pc <= JumpTarget;
                2'b10:   pc <= BranchTarget;
                default: pc <= ReturnAddr;
              endcase
              ifid_instr    <= NOP_INSTR;
              ifid_pc_plus1 <= 16'h0000;
              ifid_valid    <= 1'b0;
            end
          end
        end
        HALT: begin
          ifid_instr    <= NOP_INSTR;
          ifid_pc_plus1 <= 16'h0000;
          ifid_valid    <= 1'b0;
        end
        default: begin
          ifid_instr    <= NOP_INSTR;
          ifid_pc_plus1 <= 16'h0000;
          ifid_valid    <= 1'b0;
          state         <= BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Counters stick at all-ones rather than wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 16'h0000;
      flush_count <= 16'h0000;
    end else begin
      if (fetch_event && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
      if (flush_event && (flush_count != 16'hFFFF))
        flush_count <= flush_count + 16'd1;
    end
  end
`else
  logic unused_events;
  assign unused_events = fetch_event ^ flush_event;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; instruction memory returns address + 16'hA000.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  PCSrc;
  logic [15:0] JumpTarget;
  logic [15:0] BranchTarget;
  logic [15:0] ReturnAddr;
  logic        stall;
  logic        halt;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic [15:0] pc;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [15:0] flush_count;
`endif

  int error_count = 0;
  int check_count = 0;

  fetch_stage #(
    .RESET_VECTOR(16'h0000),
    .NOP_INSTR   (16'hF00F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrc        (PCSrc),
    .JumpTarget   (JumpTarget),
    .BranchTarget (BranchTarget),
    .ReturnAddr   (ReturnAddr),
    .stall        (stall),
    .halt         (halt),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid   (ifid_valid),
    .pc           (pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
`endif
  );

  assign imem_data = imem_addr + 16'hA000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] src, input logic stl, input logic hlt);
    PCSrc = src;
    stall = stl;
    halt  = hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfid(input string tag, input logic [15:0] exp_pc, input logic [15:0] exp_instr,
                           input logic [15:0] exp_pp1, input logic exp_valid);
    checkOutput({tag, ".pc"}, pc, exp_pc);
    checkOutput({tag, ".instr"}, ifid_instr, exp_instr);
    checkOutput({tag, ".pc_plus1"}, ifid_pc_plus1, exp_pp1);
    checkOutput({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, exp_valid});
  endtask

  initial begin
    reset = 1'b1; PCSrc = 2'b00; stall = 1'b0; halt = 1'b0;
    JumpTarget = 16'h0000; BranchTarget = 16'h0000; ReturnAddr = 16'h0000;
    #2;
    checkIfid("reset", 16'h0000, 16'hF00F, 16'h0000, 1'b0);
    checkOutput("reset.imem_addr", imem_addr, 16'h0000);
    #10;
    reset = 1'b0;

    // Boot bubble, then sequential fetch of A, B, C, D, E
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("boot", 16'h0000, 16'hF00F, 16'h0000, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("seqA", 16'h0001, 16'hA000, 16'h0001, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("seqB", 16'h0002, 16'hA001, 16'h0002, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("seqC", 16'h0003, 16'hA002, 16'h0003, 1'b1);
    applyStimulus(2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("seqE", 16'h0005, 16'hA004, 16'h0005, 1'b1);
`ifdef FETCH_PERF_EN
    checkOutput("perf.fetch5", fetch_count, 16'd5);
    checkOutput("perf.flush0", flush_count, 16'd0);
`endif

    // Taken branch from pc 5 to 0x20
    BranchTarget = 16'h0020;
    applyStimulus(2'b10, 1'b0, 1'b0);
    checkIfid("branch", 16'h0020, 16'hF00F, 16'h0000, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("branch.next", 16'h0021, 16'hA020, 16'h0021, 1'b1);
`ifdef FETCH_PERF_EN
    checkOutput("perf.fetch6", fetch_count, 16'd6);
    checkOutput("perf.flush1", flush_count, 16'd1);
`endif

    // Stall beats a pending jump for three cycles
    JumpTarget = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0);
      checkIfid($sformatf("stall%0d", i), 16'h0021, 16'hA020, 16'h0021, 1'b1);
    end
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkIfid("stall.release", 16'h0100, 16'hF00F, 16'h0000, 1'b0);

    // Return to the current pc is still a redirect
    ReturnAddr = 16'h0100;
    applyStimulus(2'b11, 1'b0, 1'b0);
    checkIfid("ret.self", 16'h0100, 16'hF00F, 16'h0000, 1'b0);

    // PC wrap at 0xFFFF
    JumpTarget = 16'hFFFF;
    applyStimulus(2'b01, 1'b0, 1'b0);
    checkOutput("jump.ffff", pc, 16'hFFFF);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("wrap", 16'h0000, 16'h9FFF, 16'h0000, 1'b1);
`ifdef FETCH_PERF_EN
    checkOutput("perf.fetch7", fetch_count, 16'd7);
    checkOutput("perf.flush4", flush_count, 16'd4);
`endif

    // Advance to pc 7 then halt while stalled
    for (int i = 0; i < 7; i++) applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("pc7", 16'h0007, 16'hA006, 16'h0007, 1'b1);
    applyStimulus(2'b00, 1'b1, 1'b1);
    checkIfid("halt", 16'h0007, 16'hF00F, 16'h0000, 1'b0);
    JumpTarget = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b0, 1'b0);
      checkIfid($sformatf("halted%0d", i), 16'h0007, 16'hF00F, 16'h0000, 1'b0);
    end

    // Asynchronous reset out of HALT, then a fresh boot
    reset = 1'b1;
    #1;
    checkIfid("rst.halt", 16'h0000, 16'hF00F, 16'h0000, 1'b0);
`ifdef FETCH_PERF_EN
    checkOutput("perf.rst.fetch", fetch_count, 16'd0);
    checkOutput("perf.rst.flush", flush_count, 16'd0);
`endif
    #2;
    reset = 1'b0;
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("reboot", 16'h0000, 16'hF00F, 16'h0000, 1'b0);
    applyStimulus(2'b00, 1'b0, 1'b0);
    checkIfid("reboot.A", 16'h0001, 16'hA000, 16'h0001, 1'b1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
